counter_load_sequencer: RTL
===========================

// Module: counter_load_sequencer
// PURPOSE
//   Shares one 8-bit loadable counter between NUM_REQ requesters. Arbitrates load requests,
//   then drives the counter's load/write controls: load held LOAD_HOLD cycles with write low
//   (the counter only accepts a load once its registered enable has cleared), then a
//   WRITE_LEN-cycle count/write window. Sits between request sources and the counter block.
// PARAMETERS
//   NUM_REQ    4  number of requesters (2..8)
//   WIDTH      8  load value width; matches the counter
//   LOAD_HOLD  2  cycles out_load_now is held; values <2 are treated as 2
//   WRITE_LEN  4  cycles out_write_now is held after load (>=1)
// PORTS
//   in_clk          in   1              clock, rising edge
//   in_rst_n        in   1              async reset, active low
//   in_req          in   NUM_REQ        per-requester request level; held until out_done
//   in_req_value    in   NUM_REQ*WIDTH  per-requester load value, slice i = [i*WIDTH +: WIDTH]
//   out_grant       out  NUM_REQ        one-hot owner, LOAD through DONE
//   out_load_value  out  WIDTH          value captured from the granted slice
//   out_load_now    out  1              to counter in_load_now
//   out_write_now   out  1              to counter in_write_now
//   out_busy        out  1              state != IDLE
//   out_done        out  1              1-cycle pulse: sequence completed for out_grant owner
// BEHAVIOUR
//   - Reset (async, any state): state IDLE; all outputs 0; RR pointer 0; cycle counter 0.
//   - One clock; every output is registered.
//   - IDLE: if in_req != 0, pick a winner and on that edge capture its value into
//     out_load_value, set out_grant, and enter LOAD. No request -> stay IDLE, outputs 0.
//   - Round-robin: search starts at ptr, wraps at NUM_REQ-1 -> 0; on grant, ptr = winner+1
//     (mod NUM_REQ). A lone requester is re-granted back-to-back.
//   - LOAD: out_load_now=1, out_write_now=0 for exactly max(LOAD_HOLD,2) cycles -> RUN.
//   - RUN: out_load_now=0, out_write_now=1 for exactly WRITE_LEN cycles -> DONE.
//   - DONE: 1 cycle; out_done=1, load/write 0, out_grant still valid -> IDLE (grant clears).
//   - Latency: request seen in IDLE -> out_load_now high the next cycle; total sequence
//     = 1 + LOAD_HOLD + WRITE_LEN + 1 cycles from request edge to IDLE.
//   - Abort: owner's in_req low in LOAD or RUN -> next edge IDLE; load/write/grant drop to 0;
//     no out_done pulse; ptr already advanced (no retry priority).
//   - Other requesters' in_req changes while busy: ignored until IDLE.
//   - in_req_value sampled only at grant; later changes do not affect out_load_value.
//   - out_load_value holds last captured value until next grant (not cleared in IDLE).
//   - out_load_now and out_write_now are never both 1.
//   - Cycle counter width $clog2(max(LOAD_HOLD,WRITE_LEN)+1); reload 0 on every transition.
// CONFIGURATION
//   COUNTER_SEQ_FIXED_PRIO_EN defined: fixed priority, lowest index wins; ptr unused (const 0).
//   Not defined (default): round-robin as above. FSM/timing identical in both builds.
// TESTING
//   1 Reset mid-RUN: assert in_rst_n=0 -> same cycle all outputs 0, out_busy=0; release -> IDLE.
//   2 Single req: in_req=4'b0010, slice1=8'hA5 -> next cycle grant=0010, load_now=1,
//     load_value=A5 for 2 cycles; write_now=1 for 4 cycles; done pulse; counter loads A5.
//   3 RR fairness: in_req=4'b1111 held -> grants 0001,0010,0100,1000,0001 in order,
//     each separated by a full 8-cycle sequence.
//   4 Abort: owner drops in_req in 2nd RUN cycle -> next cycle write_now=0, grant=0,
//     no done; pending req3 granted on following cycle.
//   5 Value stability: change granted slice during LOAD -> out_load_value unchanged.
//   6 With COUNTER_SEQ_FIXED_PRIO_EN, in_req=4'b1010 held -> grant 0010 every sequence.

Source files
------------

// File: rtl/counter_load_sequencer.sv
// Arbitrates NUM_REQ load requests onto one shared loadable counter: LOAD hold, WRITE window, DONE pulse.
// Define COUNTER_SEQ_FIXED_PRIO_EN for fixed lowest-index-wins arbitration; round-robin otherwise.
module counter_load_sequencer #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int LOAD_HOLD = 2,
  parameter int WRITE_LEN = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  input  logic [NUM_REQ-1:0]       in_req,
  input  logic [NUM_REQ*WIDTH-1:0] in_req_value,
  output logic [NUM_REQ-1:0]       out_grant,
  output logic [WIDTH-1:0]         out_load_value,
  output logic                     out_load_now,
  output logic                     out_write_now,
  output logic                     out_busy,
  output logic                     out_done
);

  // The counter needs at least two load cycles for its registered enable to clear.
  localparam int LH    = (LOAD_HOLD < 2) ? 2 : LOAD_HOLD;
  localparam int CMAX  = (LH > WRITE_LEN) ? LH : WRITE_LEN;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LH_LAST = CNT_W'(LH - 1);
  localparam logic [CNT_W-1:0] WL_LAST = CNT_W'(WRITE_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]     val_q, val_d;
  logic                 ld_q, ld_d;
  logic                 wr_q, wr_d;
  logic                 dn_q, dn_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [PTR_W-1:0]     win;
  logic                 owner_req;

  assign owner_req = |(in_req & grant_q);

`ifdef COUNTER_SEQ_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (in_req[k]) begin
        found = 1'b1;
        win   = PTR_W'(k);
      end
    end
  end
`else
  // Search from ptr upward, wrapping at NUM_REQ-1.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && in_req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    val_d   = val_q;
    ld_d    = 1'b0;
    wr_d    = 1'b0;
    dn_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          state_d = LOAD;
          cnt_d   = '0;
          grant_d = NUM_REQ'(1) << win;
          val_d   = in_req_value[win*WIDTH +: WIDTH];
          ld_d    = 1'b1;
`ifdef COUNTER_SEQ_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      LOAD: begin
        if (!owner_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else if (cnt_q == LH_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          wr_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          ld_d    = 1'b1;
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else if (cnt_q == WL_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dn_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          wr_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      val_q   <= '0;
      ld_q    <= 1'b0;
      wr_q    <= 1'b0;
      dn_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      val_q   <= val_d;
      ld_q    <= ld_d;
      wr_q    <= wr_d;
      dn_q    <= dn_d;
      busy_q  <= busy_d;
    end
  end

  assign out_grant      = grant_q;
  assign out_load_value = val_q;
  assign out_load_now   = ld_q;
  assign out_write_now  = wr_q;
  assign out_busy       = busy_q;
  assign out_done       = dn_q;

endmodule
